// File: rtl/sdm_pkg.sv
// Shared helpers for the time-multiplexed sigma-delta scheduler: the +ONE word,
// the channel-index width and a default signed error-word type.
package sdm_pkg;

    localparam int SDM_DEFAULT_BW = 16;

    typedef logic signed [SDM_DEFAULT_BW-1:0] sdm_err_t;

    function automatic int sdm_one(input int bit_width, input int int_width);
        return 1 << (bit_width - int_width - 1);
    endfunction

    function automatic int sdm_ch_w(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/sdm_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible channel at or after ptr,
// wrapping from N_CH-1 back to 0.
module sdm_rr_arbiter
    import sdm_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CH_W = sdm_ch_w(N_CH)
) (
    input  logic [N_CH-1:0] elig,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] idx
);

    always_comb begin
        int   c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int o = 0; o < N_CH; o++) begin
            c = int'(ptr) + o;
            if (c >= N_CH) c = c - N_CH;
            if (en && !found && elig[c]) begin
                gnt[c] = 1'b1;
                idx    = CH_W'(c);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdm_tdm_scheduler.sv
// One sigma-delta modulator shared by N_CH channels through a round-robin grant.
// Define SDM_SAT_EN to clamp the error update instead of letting it wrap.
module sdm_tdm_scheduler
    import sdm_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int BIT_WIDTH = 16,
    parameter int INT_WIDTH = 1,
    localparam int CH_W     = sdm_ch_w(N_CH)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH*BIT_WIDTH-1:0] x,
    input  logic [N_CH-1:0]           clr,
    output logic [N_CH-1:0]           ack,
    output logic                      y_valid,
    output logic                      y,
    output logic [CH_W-1:0]           y_ch,
    input  logic                      y_ready
);

    typedef logic signed [BIT_WIDTH-1:0] err_t;
    localparam err_t ONE = err_t'(sdm_one(BIT_WIDTH, INT_WIDTH));

    err_t            err [N_CH];
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gidx;
    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] gnt;
    logic            en;
    logic            granted;
    logic            b;
    err_t            xk;
    err_t            ek;
    err_t            err_nxt;

    assign elig    = req & ~clr;
    assign en      = (~y_valid | y_ready) & nRST;
    assign ack     = gnt;
    assign granted = |gnt;

    sdm_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .elig (elig),
        .ptr  (ptr),
        .en   (en),
        .gnt  (gnt),
        .idx  (gidx)
    );

    assign xk = $signed(x[gidx*BIT_WIDTH +: BIT_WIDTH]);
    assign ek = err[gidx];
    assign b  = (xk >= ek);

`ifdef SDM_SAT_EN
    // Two guard bits hold the worst case of ONE - x + err without overflow.
    localparam int EXT_W = BIT_WIDTH + 2;
    localparam logic signed [EXT_W-1:0] MAXV = {{3{1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MINV = {{3{1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    logic signed [EXT_W-1:0] one_ext;
    logic signed [EXT_W-1:0] x_ext;
    logic signed [EXT_W-1:0] e_ext;
    logic signed [EXT_W-1:0] sum_ext;

    assign one_ext = {2'b00, ONE};
    assign x_ext   = {{2{xk[BIT_WIDTH-1]}}, xk};
    assign e_ext   = {{2{ek[BIT_WIDTH-1]}}, ek};
    assign sum_ext = (b ? one_ext : -one_ext) - x_ext + e_ext;

    always_comb begin
        err_nxt = sum_ext[BIT_WIDTH-1:0];
        if (sum_ext > MAXV)      err_nxt = MAXV[BIT_WIDTH-1:0];
        else if (sum_ext < MINV) err_nxt = MINV[BIT_WIDTH-1:0];
    end
`else
    assign err_nxt = (b ? ONE : -ONE) - xk + ek;
`endif

    // clr and grant never hit the same channel, since clr removes eligibility.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < N_CH; i++) err[i] <= '0;
            ptr     <= '0;
            y_valid <= 1'b0;
            y       <= 1'b0;
            y_ch    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr[i])      err[i] <= '0;
                else if (gnt[i]) err[i] <= err_nxt;
            end
            if (granted) begin
                y       <= b;
                y_ch    <= gidx;
                y_valid <= 1'b1;
                ptr     <= (gidx == CH_W'(N_CH-1)) ? '0 : gidx + 1'b1;
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdm_tdm_scheduler.sv
// Directed bench for sdm_tdm_scheduler (N_CH=4, BIT_WIDTH=16, ONE=0x4000);
// expectations follow SDM_SAT_EN when it is defined.
module tb_sdm_tdm_scheduler;

    logic        CLK;
    logic        nRST;
    logic [3:0]  req;
    logic [63:0] x;
    logic [3:0]  clr;
    logic [3:0]  ack;
    logic        y_valid;
    logic        y;
    logic [1:0]  y_ch;
    logic        y_ready;

    int assertions = 0;
    int failures   = 0;
    int cnt [4];
    int ch;

    localparam logic [15:0] HALF = 16'h2000;

    logic        pat  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] t1e  [4] = '{16'h2000, 16'h4000, 16'hE000, 16'h0000};
`ifdef SDM_SAT_EN
    logic        t6y  [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] t6e  [3] = '{16'h4000, 16'h7FFF, 16'h7FFF};
`else
    logic        t6y  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] t6e  [3] = '{16'h4000, 16'h8000, 16'h4000};
`endif

    sdm_tdm_scheduler #(.N_CH(4), .BIT_WIDTH(16), .INT_WIDTH(1)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .req     (req),
        .x       (x),
        .clr     (clr),
        .ack     (ack),
        .y_valid (y_valid),
        .y       (y),
        .y_ch    (y_ch),
        .y_ready (y_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c, input logic rdy, input logic rst_n);
        req     = r;
        clr     = c;
        y_ready = rdy;
        nRST    = rst_n;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        nRST    = 1'b0;
        req     = '0;
        clr     = '0;
        x       = '0;
        y_ready = 1'b1;
        @(posedge CLK);
        #1;

        // Reset state, with requests present while reset is held
        x = {4{HALF}};
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        tick();
        checkOutput("rst_y_valid", 32'(y_valid), 32'h0);
        checkOutput("rst_y", 32'(y), 32'h0);
        checkOutput("rst_y_ch", 32'(y_ch), 32'h0);
        checkOutput("rst_ptr", 32'(dut.ptr), 32'h0);
        for (int i = 0; i < 4; i++) checkOutput("rst_err", {16'h0, dut.err[i]}, 32'h0);

        // Single channel at 0.5: y = 1,1,0,1 repeating
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1);
            checkOutput("t1_ack", 32'(ack), 32'h1);
            tick();
            checkOutput("t1_y", 32'(y), 32'(pat[i%4]));
            checkOutput("t1_y_valid", 32'(y_valid), 32'h1);
            checkOutput("t1_y_ch", 32'(y_ch), 32'h0);
            checkOutput("t1_err0", {16'h0, dut.err[0]}, {16'h0, t1e[i%4]});
        end

        // All channels requesting: gapless rotation 0,1,2,3,...
        doReset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 10; i++) begin
            ch = i % 4;
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
            checkOutput("t2_ack", 32'(ack), 32'(1 << ch));
            tick();
            checkOutput("t2_y_ch", 32'(y_ch), 32'(ch));
            checkOutput("t2_y_valid", 32'(y_valid), 32'h1);
            checkOutput("t2_y", 32'(y), 32'(pat[cnt[ch]%4]));
            cnt[ch]++;
        end

        // Consumer stall: no grants, output held, resume at the next channel
        for (int s = 0; s < 3; s++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b1);
            checkOutput("t3_stall_ack", 32'(ack), 32'h0);
            tick();
            checkOutput("t3_stall_y_ch", 32'(y_ch), 32'h1);
            checkOutput("t3_stall_y_valid", 32'(y_valid), 32'h1);
            checkOutput("t3_stall_y", 32'(y), 32'(pat[(cnt[1]-1)%4]));
        end
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
        checkOutput("t3_resume_ack", 32'(ack), 32'h4);
        tick();
        checkOutput("t3_resume_y_ch", 32'(y_ch), 32'h2);

        // clr beats a same-cycle request on the same channel
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1);
        checkOutput("t4_pre_ack", 32'(ack), 32'h2);
        tick();
        checkOutput("t4_pre_err1", {16'h0, dut.err[1]}, 32'h2000);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b1);
        checkOutput("t4_clr_ack", 32'(ack), 32'h0);
        tick();
        checkOutput("t4_clr_err1", {16'h0, dut.err[1]}, 32'h0);
        checkOutput("t4_clr_y_valid", 32'(y_valid), 32'h0);
        applyStimulus(4'b0010, 4'b0001, 1'b1, 1'b1);
        checkOutput("t4_post_ack", 32'(ack), 32'h2);
        tick();
        checkOutput("t4_post_y", 32'(y), 32'h1);
        checkOutput("t4_post_y_ch", 32'(y_ch), 32'h1);
        checkOutput("t4_post_err1", {16'h0, dut.err[1]}, 32'h2000);

        // Reset mid-stream drops the output, pointer and accumulators
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
            tick();
        end
        checkOutput("t5_pre_err2", {16'h0, dut.err[2]}, 32'h2000);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
        checkOutput("t5_rst_ack", 32'(ack), 32'h0);
        tick();
        checkOutput("t5_y_valid", 32'(y_valid), 32'h0);
        checkOutput("t5_ptr", 32'(dut.ptr), 32'h0);
        for (int i = 0; i < 4; i++) checkOutput("t5_err", {16'h0, dut.err[i]}, 32'h0);
        applyStimulus(4'b1110, 4'b0000, 1'b1, 1'b1);
        checkOutput("t5_first_ack", 32'(ack), 32'h2);
        tick();
        checkOutput("t5_first_y_ch", 32'(y_ch), 32'h1);

        // Full-scale negative input: wrap (or clamp) of the error word
        doReset();
        x = '0;
        x[15:0] = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1);
            checkOutput("t6_ack", 32'(ack), 32'h1);
            tick();
            checkOutput("t6_y", 32'(y), 32'(t6y[i]));
            checkOutput("t6_err0", {16'h0, dut.err[0]}, {16'h0, t6e[i]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
